// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding and timeout constants for the SPI arbiter.
package spi_arb_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, FINISH} state_t;
  localparam int TMO_DEF = 1023;
  localparam logic [15:0] TMO_DATA = 16'hFFFF;
endpackage

// File: rtl/rr_sel2.sv
// rr_sel2: two-way round-robin pick; winner=1 selects requester 1.
module rr_sel2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);
  // On a tie the requester not served last wins; a lone request always wins.
  assign winner = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter sharing one SPI master between the inertial
// and A2D requesters, with a BUSY-state timeout that returns 16'hFFFF.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int TMO_CYC = TMO_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] cmd0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        tmo_err
);
  state_t      r_state;
  logic        r_last;
  logic        r_sel;
  logic [9:0]  r_cnt;
  logic        w_win;

  rr_sel2 u_sel (.req0(req0), .req1(req1), .last(r_last), .winner(w_win));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      wrt     <= 1'b0;
      tmo_err <= 1'b0;
      cmd     <= '0;
      rd_data <= '0;
    end else begin
      wrt   <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        IDLE: if (req0 | req1) begin
          r_sel   <= w_win;
          cmd     <= w_win ? cmd1 : cmd0;
          gnt0    <= ~w_win;
          gnt1    <= w_win;
          wrt     <= 1'b1;
          r_state <= LAUNCH;
        end
        LAUNCH: begin
          r_cnt   <= '0;
          r_state <= BUSY;
        end
        // spi_done wins over a coinciding timeout
        BUSY: if (spi_done || r_cnt == 10'(TMO_CYC - 1)) begin
          rd_data <= spi_done ? spi_rd_data : TMO_DATA;
          tmo_err <= tmo_err | ~spi_done;
          done0   <= ~r_sel;
          done1   <= r_sel;
          r_state <= FINISH;
        end else begin
          r_cnt <= r_cnt + 10'd1;
        end
        FINISH: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          r_last  <= r_sel;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: directed self-checking bench for spi_arb using immediate assertions.
module tb_spi_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, spi_done = 1'b0;
  logic [15:0] cmd0 = '0, cmd1 = '0, spi_rd_data = '0;
  logic        gnt0, gnt1, done0, done1, wrt, tmo_err;
  logic [15:0] rd_data, cmd;
  int checks = 0;
  int errors = 0;

  spi_arb dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One transaction from IDLE with requests already applied; returns in IDLE (M+2).
  task automatic xact(input logic sel, input logic [15:0] exp_cmd, input logic [15:0] rdv);
    tick();
    chk("grant", {14'd0, gnt1, gnt0}, sel ? 16'd2 : 16'd1);
    chk("wrt_hi", {15'd0, wrt}, 16'd1);
    chk("cmd", cmd, exp_cmd);
    tick();
    chk("wrt_lo", {15'd0, wrt}, 16'd0);
    chk("busy_grant", {14'd0, gnt1, gnt0}, sel ? 16'd2 : 16'd1);
    spi_done = 1'b1;
    spi_rd_data = rdv;
    tick();
    spi_done = 1'b0;
    chk("done", {14'd0, done1, done0}, sel ? 16'd2 : 16'd1);
    chk("rd_data", rd_data, rdv);
    tick();
    chk("release", {12'd0, gnt1, gnt0, done1, done0}, 16'd0);
  endtask

  initial begin
    tick();
    chk("rst_ctl", {10'd0, gnt0, gnt1, done0, done1, wrt, tmo_err}, 16'd0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rd", rd_data, 16'h0000);
    tick();
    rst_n = 1'b1;

    // First tie goes to requester 0
    req0 = 1'b1; req1 = 1'b1; cmd0 = 16'hA5A5; cmd1 = 16'h5A5A;
    xact(1'b0, 16'hA5A5, 16'h1234);
    req0 = 1'b0; req1 = 1'b0;

    // Round robin with both held, starting from reset state
    do_reset();
    req0 = 1'b1; req1 = 1'b1; cmd0 = 16'h1111; cmd1 = 16'h2222;
    xact(1'b0, 16'h1111, 16'h0101);
    xact(1'b1, 16'h2222, 16'h0202);
    xact(1'b0, 16'h1111, 16'h0303);
    xact(1'b1, 16'h2222, 16'h0404);
    req0 = 1'b0; req1 = 1'b0;

    // Timeout on requester 1
    req1 = 1'b1; cmd1 = 16'hBEEF;
    tick();
    chk("tmo_grant", {14'd0, gnt1, gnt0}, 16'd2);
    repeat (1023) tick();
    chk("tmo_pre", {13'd0, done1, done0, tmo_err}, 16'd0);
    tick();
    chk("tmo_done", {13'd0, done1, done0, tmo_err}, 16'b101);
    chk("tmo_rd", rd_data, 16'hFFFF);
    req1 = 1'b0;
    tick();
    chk("tmo_rel", {13'd0, gnt1, gnt0, tmo_err}, 16'd1);
    req0 = 1'b1; cmd0 = 16'h0F0F;
    xact(1'b0, 16'h0F0F, 16'h4321);
    req0 = 1'b0;
    chk("tmo_sticky", {15'd0, tmo_err}, 16'd1);

    // spi_done in the exact timeout cycle
    do_reset();
    req0 = 1'b1; cmd0 = 16'hC3C3;
    tick();
    repeat (1023) tick();
    chk("edge_pre", {14'd0, done1, done0}, 16'd0);
    spi_done = 1'b1; spi_rd_data = 16'h7777;
    tick();
    spi_done = 1'b0;
    chk("edge_done", {13'd0, done1, done0, tmo_err}, 16'b010);
    chk("edge_rd", rd_data, 16'h7777);
    req0 = 1'b0;
    tick();

    // Reset during BUSY
    req1 = 1'b1; cmd1 = 16'h9999;
    tick();
    tick();
    chk("pre_rst_gnt", {15'd0, gnt1}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("async_ctl", {10'd0, gnt0, gnt1, done0, done1, wrt, tmo_err}, 16'd0);
    chk("async_cmd", cmd, 16'h0000);
    chk("async_rd", rd_data, 16'h0000);
    req1 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("no_done", {14'd0, done1, done0}, 16'd0);
    req0 = 1'b1; cmd0 = 16'h1357;
    xact(1'b0, 16'h1357, 16'h2468);
    req0 = 1'b0;

    // req0 drop and cmd0 change mid-transaction
    req0 = 1'b1; cmd0 = 16'hAAAA;
    tick();
    chk("hold_cmd0", cmd, 16'hAAAA);
    tick();
    req0 = 1'b0; cmd0 = 16'h5555;
    tick();
    chk("hold_cmd1", cmd, 16'hAAAA);
    spi_done = 1'b1; spi_rd_data = 16'hBBBB;
    tick();
    spi_done = 1'b0;
    chk("hold_done", {14'd0, done1, done0}, 16'd1);
    chk("hold_rd", rd_data, 16'hBBBB);
    tick();
    chk("hold_rel", {14'd0, gnt1, gnt0}, 16'd0);

    // spi_done while idle is ignored
    spi_done = 1'b1; spi_rd_data = 16'hDEAD;
    tick();
    spi_done = 1'b0;
    tick();
    chk("idle_rd", rd_data, 16'hBBBB);
    chk("idle_ctl", {12'd0, gnt1, gnt0, done1, done0}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 Parameter TMO_CYC, default 1023, SHALL set the BUSY-state cycle limit before a transaction is aborted.
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0  input  1  inertial requester transaction request, level, held until done0.
REQ-005 cmd0  input  16  inertial SPI command word, valid while req0 high.
REQ-006 req1  input  1  A2D requester transaction request, level, held until done1.
REQ-007 cmd1  input  16  A2D SPI command word, valid while req1 high.
REQ-008 gnt0, gnt1  output  1 each  grant indicators, at most one high at any time.
REQ-009 done0, done1  output  1 each  one-cycle completion pulses to the granted requester.
REQ-010 rd_data  output  16  captured SPI read data, valid in the done cycle, held until the next capture.
REQ-011 wrt  output  1  one-cycle launch strobe to the shared SPI master.
REQ-012 cmd  output  16  registered command word to the SPI master, stable from the wrt cycle to done.
REQ-013 spi_done  input  1  SPI master completion pulse.
REQ-014 spi_rd_data  input  16  SPI master read data, valid with spi_done.
REQ-015 tmo_err  output  1  sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, BUSY, FINISH.
REQ-017 IDLE: if req0 or req1 is sampled high in cycle N, SHALL register the winner's cmd, assert its gnt and enter LAUNCH at N+1.
REQ-018 Arbitration SHALL be round-robin: if both requests are high, the requester not served last wins; a single request wins unconditionally.
REQ-019 LAUNCH: wrt SHALL be high for exactly that one cycle (N+1); next state SHALL be BUSY.
REQ-020 BUSY: spi_done in cycle M SHALL capture spi_rd_data into rd_data and enter FINISH at M+1.
REQ-021 FINISH: the granted requester's done SHALL pulse for one cycle (M+1); gnt SHALL drop and last-served SHALL update at M+2, with the state returning to IDLE.
REQ-022 The earliest next grant after a completion SHALL be at M+3.
REQ-023 A req deasserted mid-transaction SHALL be ignored; the transaction SHALL complete and done SHALL still pulse.
REQ-024 spi_done outside BUSY SHALL be ignored.
REQ-025 A 10-bit BUSY cycle counter SHALL clear on LAUNCH; when it reaches TMO_CYC with no spi_done, the block SHALL set tmo_err, load rd_data with 16'hFFFF and enter FINISH.
REQ-026 tmo_err SHALL stay high until reset.
REQ-027 If spi_done coincides with the timeout count, spi_done SHALL take priority and tmo_err SHALL NOT set.
REQ-028 cmd0/cmd1 changes after the grant SHALL NOT affect cmd.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously enter IDLE and clear gnt0, gnt1, done0, done1, wrt and tmo_err.
REQ-030 On rst_n low, cmd and rd_data SHALL be cleared to 16'h0000, and last-served SHALL be set to requester 1 so that requester 0 wins the first tie.
REQ-031 Reset mid-transaction SHALL abort the transaction with no done pulse; the SPI master shares rst_n.

Structure
REQ-032 State encoding, the TMO_CYC default and the timeout data value 16'hFFFF SHALL reside in shared package spi_arb_pkg.
REQ-033 A round-robin selector sub-module rr_sel2 (inputs req0, req1, last; output winner) SHALL be the only sub-module.

Verification
REQ-034 After reset, req0 and req1 rise together, cmd0=16'hA5A5 -> gnt0 and wrt=1 one cycle later with cmd=16'hA5A5; spi_done with spi_rd_data=16'h1234 -> done0 next cycle, rd_data=16'h1234.
REQ-035 Both requests are held high for four transactions -> grant order 0,1,0,1, with gnt0 and gnt1 never high together.
REQ-036 req1 only, no spi_done -> after 1023 BUSY cycles: done1 pulses, rd_data=16'hFFFF, tmo_err=1 and remains 1 through later good transactions.
REQ-037 spi_done arrives in the exact timeout cycle -> normal capture, tmo_err stays 0.
REQ-038 rst_n is pulsed low during BUSY -> all outputs zero immediately; no done pulse; the next request is served normally.
REQ-039 req0 drops and cmd0 changes during BUSY -> cmd unchanged, and done0 still pulses on spi_done.
